dbg_csr_bridge: RTL and testbench
=================================

// Module: dbg_csr_bridge
// PURPOSE
//  Converts debug-port CSR access requests into the core's CSR valid/ready
//  request/response protocol. Drives master port 1 (debug master) of the 2-master
//  CSR interconnect that arbitrates between the executor and debug.
//  One outstanding transaction at a time. A timeout covers a stalled interconnect.
//  Late responses that arrive after a timeout are drained silently.
// PARAMETERS
//  TMO_BITS      8     width of the timeout counter
//  TMO_LIMIT     255   cycles in REQ+WAIT_RESP before timeout; range 1..2^TMO_BITS-1
// PORTS
//  i_clk                input   1   clock, rising edge
//  i_nrst               input   1   asynchronous reset, active low
//  i_dport_req_valid    input   1   debug CSR request valid
//  o_dport_req_ready    output  1   bridge accepts request
//  i_dport_write        input   1   1=write, 0=read
//  i_dport_addr         input   12  CSR address
//  i_dport_wdata        input   64  write data
//  o_dport_resp_valid   output  1   response valid to debug port
//  i_dport_resp_ready   input   1   debug port accepts response
//  o_dport_rdata        output  64  read data (0 on write/error)
//  o_dport_error        output  1   CSR exception or timeout
//  o_csr_req_valid      output  1   request to interconnect master 1
//  i_csr_req_ready      input   1   interconnect accepts request
//  o_csr_req_type       output  2   2'b01 read, 2'b10 write
//  o_csr_req_addr       output  12  latched CSR address
//  o_csr_req_data       output  64  latched write data
//  i_csr_resp_valid     input   1   CSR response valid
//  o_csr_resp_ready     output  1   bridge accepts response
//  i_csr_resp_data      input   64  CSR read data
//  i_csr_resp_exception input   1   access faulted
// BEHAVIOUR
//  - Reset is async, active low. State=IDLE; drop=0; tmo=0; addr/data/type/rdata=0; error=0.
//    Every output is 0 except o_dport_req_ready=1.
//  - IDLE: o_dport_req_ready = !drop.
//    On req_valid&&ready: latch type/addr/wdata, tmo<=0, go to REQ.
//  - REQ: o_csr_req_valid=1; outputs stay stable until accepted.
//    On i_csr_req_ready: go to WAIT_RESP, tmo<=0.
//  - WAIT_RESP: o_csr_resp_ready=1.
//    On i_csr_resp_valid: rdata <= write ? 0 : i_csr_resp_data; error <= exception.
//    Then go to RESP.
//  - RESP: o_dport_resp_valid=1; rdata/error held stable.
//    On i_dport_resp_ready: go to IDLE.
//  - Timeout: tmo increments each cycle in REQ and WAIT_RESP.
//    When tmo==TMO_LIMIT-1 and no handshake completes that cycle: rdata<=0, error<=1, go to RESP.
//  - Timeout in REQ: req_valid drops; drop stays 0, because the interconnect was never acquired.
//  - Timeout in WAIT_RESP: drop<=1. While drop=1, o_csr_resp_ready=1 in every state.
//    The next i_csr_resp_valid clears drop; its data is discarded.
//  - A handshake coincident with the timeout edge wins; no timeout occurs.
//  - Latency: dport accept at cycle N -> o_csr_req_valid at N+1.
//    csr resp at cycle M -> o_dport_resp_valid at M+1. Minimum round trip is 3 cycles.
//  - In RESP with drop=1, a draining response is consumed with no effect on rdata/error.
//  - Reset mid-transaction returns to IDLE at once; drop is cleared.
//    The CSR side must be reset together with this block.
//  - Only 1 outstanding transaction; dport_req_ready=0 outside IDLE.
// TESTING
//  1 Read 0x300, ready=1, resp data 0x1800 after 2 cycles -> rdata=0x1800, error=0, valid 1 cycle.
//  2 Write 0x341 data 0xDEAD -> o_csr_req_type=2'b10, data=0xDEAD; resp -> rdata=0, error=0.
//  3 Read, i_csr_req_ready low 255 cycles -> req_valid drops; error=1, rdata=0, drop=0.
//  4 Req accepted, no resp 255 cycles -> error=1, drop=1, dport_req_ready=0.
//    Late resp -> dropped; then ready=1.
//  5 resp_exception=1 on read 0x7B0 -> error=1; resp_ready held low 3 cycles -> outputs stable.
//  6 Assert i_nrst=0 in WAIT_RESP -> IDLE, outputs reset values; a following read completes normally.

Source files
------------

// File: rtl/dbg_csr_bridge.sv
// rtl/dbg_csr_bridge.sv - debug-port CSR access bridge onto interconnect master 1
// One outstanding transaction with a timeout; responses that arrive after a timeout are drained.
module dbg_csr_bridge #(
  parameter int TMO_BITS  = 8,
  parameter int TMO_LIMIT = 255
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_dport_req_valid,
  output logic        o_dport_req_ready,
  input  logic        i_dport_write,
  input  logic [11:0] i_dport_addr,
  input  logic [63:0] i_dport_wdata,
  output logic        o_dport_resp_valid,
  input  logic        i_dport_resp_ready,
  output logic [63:0] o_dport_rdata,
  output logic        o_dport_error,
  output logic        o_csr_req_valid,
  input  logic        i_csr_req_ready,
  output logic [1:0]  o_csr_req_type,
  output logic [11:0] o_csr_req_addr,
  output logic [63:0] o_csr_req_data,
  input  logic        i_csr_resp_valid,
  output logic        o_csr_resp_ready,
  input  logic [63:0] i_csr_resp_data,
  input  logic        i_csr_resp_exception
);

  localparam logic [TMO_BITS-1:0] TMO_LAST = TMO_BITS'(TMO_LIMIT - 1);
  localparam logic [1:0] TYPE_READ  = 2'b01;
  localparam logic [1:0] TYPE_WRITE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RESP,
    S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic                drop_q, drop_d;
  logic [TMO_BITS-1:0] tmo_q, tmo_d;
  logic [1:0]          type_q, type_d;
  logic [11:0]         addr_q, addr_d;
  logic [63:0]         wdata_q, wdata_d;
  logic [63:0]         rdata_q, rdata_d;
  logic                error_q, error_d;
  logic                tmo_hit;

  assign tmo_hit = (tmo_q == TMO_LAST);

  always_comb begin
    state_d            = state_q;
    drop_d             = drop_q;
    tmo_d              = tmo_q;
    type_d             = type_q;
    addr_d             = addr_q;
    wdata_d            = wdata_q;
    rdata_d            = rdata_q;
    error_d            = error_q;
    o_dport_req_ready  = 1'b0;
    o_dport_resp_valid = 1'b0;
    o_csr_req_valid    = 1'b0;
    // A pending late response must always be sinkable, whatever the state.
    o_csr_resp_ready   = drop_q;

    case (state_q)
      S_IDLE: begin
        o_dport_req_ready = !drop_q;
        if (i_dport_req_valid && !drop_q) begin
          type_d  = i_dport_write ? TYPE_WRITE : TYPE_READ;
          addr_d  = i_dport_addr;
          wdata_d = i_dport_wdata;
          tmo_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        o_csr_req_valid = 1'b1;
        tmo_d           = tmo_q + 1'b1;
        if (i_csr_req_ready) begin
          tmo_d   = '0;
          state_d = S_WAIT_RESP;
        end else if (tmo_hit) begin
          rdata_d = '0;
          error_d = 1'b1;
          state_d = S_RESP;
        end
      end
      S_WAIT_RESP: begin
        o_csr_resp_ready = 1'b1;
        tmo_d            = tmo_q + 1'b1;
        if (i_csr_resp_valid) begin
          rdata_d = (type_q == TYPE_WRITE) ? 64'd0 : i_csr_resp_data;
          error_d = i_csr_resp_exception;
          state_d = S_RESP;
        end else if (tmo_hit) begin
          rdata_d = '0;
          error_d = 1'b1;
          drop_d  = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        o_dport_resp_valid = 1'b1;
        if (i_dport_resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // drop_q is never set while in WAIT_RESP, so this only ever eats a stale response.
    if (drop_q && i_csr_resp_valid) drop_d = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= S_IDLE;
      drop_q  <= 1'b0;
      tmo_q   <= '0;
      type_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      tmo_q   <= tmo_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  assign o_csr_req_type = type_q;
  assign o_csr_req_addr = addr_q;
  assign o_csr_req_data = wdata_q;
  assign o_dport_rdata  = rdata_q;
  assign o_dport_error  = error_q;

endmodule

// File: tb/tb_dbg_csr_bridge.sv
// tb/tb_dbg_csr_bridge.sv - scoreboard bench for dbg_csr_bridge
module tb_dbg_csr_bridge;

  localparam int LIMIT = 255;

  logic        i_clk;
  logic        i_nrst;
  logic        i_dport_req_valid;
  logic        o_dport_req_ready;
  logic        i_dport_write;
  logic [11:0] i_dport_addr;
  logic [63:0] i_dport_wdata;
  logic        o_dport_resp_valid;
  logic        i_dport_resp_ready;
  logic [63:0] o_dport_rdata;
  logic        o_dport_error;
  logic        o_csr_req_valid;
  logic        i_csr_req_ready;
  logic [1:0]  o_csr_req_type;
  logic [11:0] o_csr_req_addr;
  logic [63:0] o_csr_req_data;
  logic        i_csr_resp_valid;
  logic        o_csr_resp_ready;
  logic [63:0] i_csr_resp_data;
  logic        i_csr_resp_exception;

  dbg_csr_bridge #(.TMO_BITS(8), .TMO_LIMIT(LIMIT)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst),
    .i_dport_req_valid(i_dport_req_valid), .o_dport_req_ready(o_dport_req_ready),
    .i_dport_write(i_dport_write), .i_dport_addr(i_dport_addr), .i_dport_wdata(i_dport_wdata),
    .o_dport_resp_valid(o_dport_resp_valid), .i_dport_resp_ready(i_dport_resp_ready),
    .o_dport_rdata(o_dport_rdata), .o_dport_error(o_dport_error),
    .o_csr_req_valid(o_csr_req_valid), .i_csr_req_ready(i_csr_req_ready),
    .o_csr_req_type(o_csr_req_type), .o_csr_req_addr(o_csr_req_addr), .o_csr_req_data(o_csr_req_data),
    .i_csr_resp_valid(i_csr_resp_valid), .o_csr_resp_ready(o_csr_resp_ready),
    .i_csr_resp_data(i_csr_resp_data), .i_csr_resp_exception(i_csr_resp_exception)
  );

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          stall_cnt = 0;
  logic [1:0]  cur_type;
  logic [11:0] cur_addr;
  logic [63:0] cur_wdata;
  logic [63:0] cur_resp_data;
  logic        cur_exc;
  int          cur_req_wait = 0;
  int          cur_resp_wait = 0;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b expected=%0b", name, act, exp);
    end
  endtask

  // CSR-side responder: holds req_ready low for cur_req_wait REQ cycles, then
  // answers cur_resp_wait cycles after the request handshake.
  initial begin
    int          req_cnt;
    int          resp_cnt;
    int          rw;
    bit          hs;
    bit          resp_pend;
    bit          expect_dvalid;
    logic [63:0] rd;
    logic        ex;
    req_cnt = 0; resp_cnt = 0; rw = 0; hs = 0; resp_pend = 0; expect_dvalid = 0;
    rd = '0; ex = 1'b0;
    i_csr_req_ready = 1'b0; i_csr_resp_valid = 1'b0;
    i_csr_resp_data = '0; i_csr_resp_exception = 1'b0;
    forever begin
      @(negedge i_clk);
      i_csr_resp_valid = 1'b0;
      if (!i_nrst) begin
        i_csr_req_ready = 1'b0;
        req_cnt = 0; hs = 0; resp_pend = 0; expect_dvalid = 0;
        continue;
      end
      if (expect_dvalid) begin
        chk1("dport_resp_latency", o_dport_resp_valid, 1'b1);
        expect_dvalid = 0;
      end
      if (hs) begin
        resp_pend = 1; resp_cnt = 0; hs = 0;
      end
      i_csr_req_ready = 1'b0;
      if (o_csr_req_valid) begin
        if (req_cnt == cur_req_wait) begin
          i_csr_req_ready = 1'b1;
          hs = 1;
          chk64("csr_req_type", 64'(o_csr_req_type), 64'(cur_type));
          chk64("csr_req_addr", 64'(o_csr_req_addr), 64'(cur_addr));
          chk64("csr_req_data", o_csr_req_data, cur_wdata);
          rw = cur_resp_wait; rd = cur_resp_data; ex = cur_exc;
        end
        req_cnt++;
      end else begin
        req_cnt = 0;
      end
      if (resp_pend) begin
        if (resp_cnt == rw) begin
          i_csr_resp_valid = 1'b1;
          i_csr_resp_data = rd;
          i_csr_resp_exception = ex;
          chk1("csr_resp_ready", o_csr_resp_ready, 1'b1);
          expect_dvalid = (rw < LIMIT);
          resp_pend = 0;
        end
        resp_cnt++;
      end
    end
  end

  // Debug-port monitor: owns resp_ready, pops the scoreboard on each response handshake.
  initial begin
    bit          held;
    logic [63:0] prev_rdata;
    logic        prev_err;
    exp_t        e;
    held = 0; prev_rdata = '0; prev_err = 1'b0;
    i_dport_resp_ready = 1'b0;
    forever begin
      @(negedge i_clk);
      if (!i_nrst) begin
        i_dport_resp_ready = 1'b0;
        held = 0;
        continue;
      end
      if (stall_cnt > 0 && o_dport_resp_valid) begin
        i_dport_resp_ready = 1'b0;
        stall_cnt--;
      end else begin
        i_dport_resp_ready = ($urandom_range(0, 3) != 0);
      end
      if (held && o_dport_resp_valid) begin
        chk64("resp_rdata_stable", o_dport_rdata, prev_rdata);
        chk1("resp_error_stable", o_dport_error, prev_err);
      end
      held = o_dport_resp_valid && !i_dport_resp_ready;
      prev_rdata = o_dport_rdata;
      prev_err = o_dport_error;
      if (o_dport_resp_valid && i_dport_resp_ready) begin
        if (exp_q.size() == 0) begin
          chk1("unexpected_resp", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk64("dport_rdata", o_dport_rdata, e.rdata);
          chk1("dport_error", o_dport_error, e.err);
        end
      end
    end
  end

  task automatic issue(input bit wr, input logic [11:0] addr, input logic [63:0] wd,
                       input int rq, input int rs, input logic [63:0] rd, input bit ex);
    exp_t e;
    int   n;
    n = 0;
    while (!o_dport_req_ready && n < 3000) begin
      @(negedge i_clk);
      n++;
    end
    chk1("dport_req_ready_wait", o_dport_req_ready, 1'b1);
    cur_type = wr ? 2'b10 : 2'b01;
    cur_addr = addr; cur_wdata = wd;
    cur_req_wait = rq; cur_resp_wait = rs;
    cur_resp_data = rd; cur_exc = ex;
    i_dport_req_valid = 1'b1;
    i_dport_write = wr; i_dport_addr = addr; i_dport_wdata = wd;
    if (rq >= LIMIT || rs >= LIMIT) begin
      e.rdata = '0;
      e.err = 1'b1;
    end else begin
      e.rdata = wr ? 64'd0 : rd;
      e.err = ex;
    end
    exp_q.push_back(e);
    @(negedge i_clk);
    i_dport_req_valid = 1'b0;
    chk1("csr_req_latency", o_csr_req_valid, 1'b1);
  endtask

  task automatic wait_popped();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge i_clk);
      n++;
    end
    chk1("resp_within_bound", n < 3000, 1'b1);
  endtask

  task automatic wait_idle();
    int n;
    wait_popped();
    n = 0;
    while (!o_dport_req_ready && n < 3000) begin
      @(negedge i_clk);
      n++;
    end
    chk1("idle_within_bound", o_dport_req_ready, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk1({tag, "_req_ready"}, o_dport_req_ready, 1'b1);
    chk1({tag, "_resp_valid"}, o_dport_resp_valid, 1'b0);
    chk1({tag, "_csr_req_valid"}, o_csr_req_valid, 1'b0);
    chk1({tag, "_csr_resp_ready"}, o_csr_resp_ready, 1'b0);
    chk64({tag, "_rdata"}, o_dport_rdata, 64'd0);
    chk1({tag, "_error"}, o_dport_error, 1'b0);
    chk64({tag, "_type_addr"}, {50'd0, o_csr_req_type, o_csr_req_addr}, 64'd0);
    chk64({tag, "_req_data"}, o_csr_req_data, 64'd0);
  endtask

  function automatic int pick_wait();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 13) return int'($urandom_range(0, 3));
    case (r)
      13: return LIMIT - 2;
      14: return LIMIT - 1;
      15: return LIMIT;
      16: return LIMIT + 1;
      default: return int'($urandom_range(4, 20));
    endcase
  endfunction

  initial begin
    i_nrst = 1'b0;
    i_dport_req_valid = 1'b0; i_dport_write = 1'b0;
    i_dport_addr = '0; i_dport_wdata = '0;
    repeat (3) @(negedge i_clk);
    check_reset_outputs("reset");
    i_nrst = 1'b1;
    @(negedge i_clk);

    issue(1'b0, 12'h300, 64'h0, 0, 2, 64'h1800, 1'b0);
    wait_idle();
    issue(1'b1, 12'h341, 64'hDEAD, 1, 1, 64'h5555_AAAA_1234_5678, 1'b0);
    wait_idle();
    issue(1'b0, 12'h305, 64'h0, 300, 0, 64'h77, 1'b0);
    wait_idle();

    issue(1'b0, 12'h123, 64'h0, 0, 300, 64'hBEEF, 1'b0);
    wait_popped();
    @(negedge i_clk);
    chk1("drop_blocks_req", o_dport_req_ready, 1'b0);
    wait_idle();
    issue(1'b0, 12'h124, 64'h0, 0, 0, 64'hCAFE_F00D, 1'b0);
    wait_idle();

    stall_cnt = 3;
    issue(1'b0, 12'h7B0, 64'h0, 2, 1, 64'h9999, 1'b1);
    wait_idle();

    issue(1'b0, 12'h310, 64'h0, 0, 50, 64'h4242, 1'b0);
    repeat (10) @(negedge i_clk);
    i_nrst = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge i_clk);
    i_nrst = 1'b1;
    @(negedge i_clk);
    issue(1'b0, 12'h311, 64'h0, 0, 1, 64'h0123_4567_89AB_CDEF, 1'b0);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom_range(0, 1)), 12'($urandom), {$urandom, $urandom},
            pick_wait(), pick_wait(), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      wait_idle();
    end

    repeat (5) @(negedge i_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    failures++;
    $display("FAIL watchdog actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
